rotary_quad_decoder: RTL and testbench

- Front-end stage for the rotary encoder: takes raw encoder channels A/B from the pins and produces clean per-detent step pulses, direction and a position count.
- Output `step` is a single-cycle qualifier; downstream combinational logic ANDs it with `dir` to form its up/down strobes.
- Contents: synchronizer, per-channel debounce filter, quadrature state decoder, detent accumulator and wrapping position counter.

---
 rtl/rotary_quad_decoder.sv | 184 ++++++++++++++++++
 tb/tb_rotary_quad_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder: front end for a mechanical rotary encoder.
// Raw A/B pins -> 2-flop synchronizer -> per-channel debounce filter ->
// quadrature decoder -> detent accumulator -> wrapping position counter.
// Outputs: step (one-cycle detent pulse), dir (held direction of last step),
// pos (wrapping count) and err (illegal-transition pulse).
// Optional feature macro: ROT_ERR_EN. When defined, a transition that
// flips both channels at once pulses err and clears the accumulator.
// When undefined, err is tied 0 and such transitions are ignored.
//
// Handshake: there is no back-pressure. step and err are single-cycle
// qualifiers with no ready; dir and pos are meaningful whenever step is 1
// and are held stable between steps.
module rotary_quad_decoder #(
  parameter int DEB_CYCLES       = 4,
  parameter int STEPS_PER_DETENT = 4,
  parameter int POS_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             err
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int ACC_W = $clog2(STEPS_PER_DETENT + 1) + 1;
  localparam logic [CNT_W-1:0]        DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_MIN  = -ACC_MAX;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              init_cnt;
  logic                    run;
  logic                    load;

  logic                    a_meta, b_meta;
  logic [1:0]              s_vec;      // {sa, sb}
  logic [1:0]              f_vec;      // {fa, fb}
  logic [1:0]              prev;
  logic [CNT_W-1:0]        deb_cnt [2];

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [1:0]              phase_diff;
  logic                    cw, ccw, illegal;

  // Gray-code position of a channel pair along the CW sequence 00-10-11-01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  // Two-flop synchronizer per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_meta <= 1'b0;
      b_meta <= 1'b0;
      s_vec  <= 2'b00;
    end else begin
      a_meta <= a;
      b_meta <= b;
      s_vec  <= {a_meta, b_meta};
    end
  end

  // FSM state register plus the start-up delay counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= 2'd0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_cnt <= init_cnt + 2'd1;
    end
  end

  // Next state: leave INIT on its third cycle, then stay in RUN.
  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_cnt == 2'd2) state_next = ST_RUN;
  end

  // FSM outputs: load captures the reference, run enables filtering/decoding.
  always_comb begin
    load = 1'b0;
    run  = 1'b0;
    case (state)
      ST_INIT: load = (init_cnt == 2'd2);
      ST_RUN:  run  = 1'b1;
      default: ;
    endcase
  end

  // Debounce: accept a new level only after it persists DEB_CYCLES clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_vec <= 2'b00;
      prev  <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else if (load) begin
      f_vec <= s_vec;
      prev  <= s_vec;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else if (run) begin
      prev <= f_vec;
      for (int i = 0; i < 2; i++) begin
        if (s_vec[i] != f_vec[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            f_vec[i]   <= s_vec[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Quadrature decode of filtered state against the previous filtered state.
  always_comb begin
    phase_diff = phase(f_vec) - phase(prev);
    cw         = (phase_diff == 2'd1);
    ccw        = (phase_diff == 2'd3);
    illegal    = (phase_diff == 2'd2);
    acc_next   = acc;
    if (cw)  acc_next = acc + ACC_ONE;
    if (ccw) acc_next = acc - ACC_ONE;
  end

  // Detent accumulator, step/dir pulse generation and position counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      step <= 1'b0;
      dir  <= 1'b0;
      pos  <= '0;
    end else begin
      step <= 1'b0;
      if (run) begin
        if (illegal) begin
`ifdef ROT_ERR_EN
          acc <= '0;
`endif
        end else if (acc_next == ACC_MAX) begin
          step <= 1'b1;
          dir  <= 1'b1;
          pos  <= pos + POS_W'(1);
          acc  <= '0;
        end else if (acc_next == ACC_MIN) begin
          step <= 1'b1;
          dir  <= 1'b0;
          pos  <= pos - POS_W'(1);
          acc  <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

`ifdef ROT_ERR_EN
  // Illegal-transition pulse, aligned with where a step would appear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= run && illegal;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Bench for rotary_quad_decoder: directed pin sequences; each expected
// step/err event is queued as {err, step, dir, pos} before the pin edge that
// should cause it, and a negedge monitor pops and compares on every pulse.
module tb_rotary_quad_decoder;

  localparam int POS_W = 8;
  localparam int W     = POS_W + 3;
  localparam int LAT   = 7;   // 2 sync + 4 debounce + 1 register

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             a   = 1'b0;
  logic             b   = 1'b0;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] pos;
  logic             err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_step_cyc = -1;
  int step_cnt = 0;
  int err_cnt  = 0;
  int edge_cyc = 0;
  int steps_before;
  logic prev_step = 1'b0;
  logic [W-1:0] got;
  logic [W-1:0] exp_v;
  logic [W-1:0] exp_q[$];

  rotary_quad_decoder #(
    .DEB_CYCLES(4),
    .STEPS_PER_DETENT(4),
    .POS_W(POS_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .step(step),
    .dir (dir),
    .pos (pos),
    .err (err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && (step || err)) begin
      got = {err, step, dir, pos};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got=%h expected=none", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          bad++;
          $display("FAIL pulse_content got=%h expected=%h", got, exp_v);
        end
      end
      if (step) begin
        step_cnt++;
        last_step_cyc = cyc;
        total++;
        if (prev_step) begin
          bad++;
          $display("FAIL back_to_back_step got=2 consecutive expected=1");
        end
      end
      if (err) err_cnt++;
    end
    prev_step = step;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive pins then hold for n clocks; returns just after a rising edge.
  task automatic drive(input logic va, input logic vb, input int n);
    a = va;
    b = vb;
    edge_cyc = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic va, input logic vb);
    rst = 1'b1;
    a = va;
    b = vb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_step", int'(step), 0);
    check("reset_dir", int'(dir), 0);
    check("reset_pos", int'(pos), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_init_pos", int'(pos), 0);
    check("post_init_err", int'(err), 0);
  endtask

  task automatic cw_detent(input logic [POS_W-1:0] exp_pos);
    drive(1'b1, 1'b0, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 20);
    exp_q.push_back({1'b0, 1'b1, 1'b1, exp_pos});
    drive(1'b0, 1'b0, 20);
    check("cw_latency", last_step_cyc - edge_cyc, LAT);
    check("cw_pos", int'(pos), int'(exp_pos));
  endtask

  task automatic ccw_detent(input logic [POS_W-1:0] exp_pos);
    drive(1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 20);
    exp_q.push_back({1'b0, 1'b1, 1'b0, exp_pos});
    drive(1'b0, 1'b0, 20);
    check("ccw_latency", last_step_cyc - edge_cyc, LAT);
    check("ccw_pos", int'(pos), int'(exp_pos));
  endtask

  initial begin
    #1;
    // 1: reset with pins at 11, init loads silently
    do_reset(1'b1, 1'b1);
    check("init11_steps", step_cnt, 0);

    // Re-reference at 00 via reset mid-operation
    do_reset(1'b0, 1'b0);
    check("init00_steps", step_cnt, 0);

    // 2: one clean CW detent
    cw_detent(8'd1);
    check("cw_step_count", step_cnt, 1);

    // 3: CCW to 0, CCW wraps to FF, CW wraps back to 00
    ccw_detent(8'd0);
    ccw_detent(8'hFF);
    cw_detent(8'h00);

    // 4: bouncy A rising edge, then finish the detent
    steps_before = step_cnt;
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 20);
    check("bounce_no_early_step", step_cnt, steps_before);
    drive(1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 20);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'd1});
    drive(1'b0, 1'b0, 20);
    check("bounce_latency", last_step_cyc - edge_cyc, LAT);
    check("bounce_step_count", step_cnt, steps_before + 1);
    check("bounce_pos", int'(pos), 1);

    // 5: half detent forward then back; a following detent must be full length
    steps_before = step_cnt;
    drive(1'b1, 1'b0, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 20);
    drive(1'b0, 1'b0, 20);
    check("half_detent_steps", step_cnt, steps_before);
    check("half_detent_pos", int'(pos), 1);
    cw_detent(8'd2);

    // 6: both channels switch together (illegal)
    steps_before = step_cnt;
`ifdef ROT_ERR_EN
    exp_q.push_back({1'b1, 1'b0, 1'b1, 8'd2});
`endif
    drive(1'b1, 1'b1, 20);
    check("illegal_steps", step_cnt, steps_before);
    check("illegal_pos", int'(pos), 2);
`ifdef ROT_ERR_EN
    check("illegal_err_count", err_cnt, 1);
`else
    check("illegal_err_count", err_cnt, 0);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
